// File: rtl/rx_frame_checker_pkg.sv
// Shared types and defaults for the receive frame checker: FSM states,
// holding-register control bits and the per-beat byte-count helper.
package rx_frame_checker_pkg;

  localparam int DEF_MIN_LEN = 64;
  localparam int DEF_MAX_LEN = 9216;
  localparam int CNT_W       = 14;
  localparam int CTR_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PKT     = 2'd1,
    ST_DISCARD = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic       vld;
    logic       sop;
    logic       eop;
    logic [1:0] res;
    logic       bad;
  } hr_ctl_t;

  // A residual of 0 on the last beat means all four bytes are valid.
  function automatic logic [CNT_W-1:0] beat_bytes(input logic eop, input logic [1:0] res);
    if (eop && res != 2'd0) return {{(CNT_W-2){1'b0}}, res};
    return CNT_W'(4);
  endfunction

endpackage

// File: rtl/rx_frame_checker_if.sv
// Beat-stream bundle used on both sides of the frame checker.
interface rx_frame_checker_if #(
  parameter int DATA_WIDTH = 32
);
  // Valid-only stream: a beat transfers on every clock where valid is high.
  // There is no ready; the sink must take every beat it is offered.
  logic                  valid;
  logic                  sop;
  logic                  eop;
  logic [1:0]            residual;
  logic [DATA_WIDTH-1:0] data;
  logic                  bad;

  modport master (output valid, sop, eop, residual, data, bad);
  modport slave  (input  valid, sop, eop, residual, data, bad);
endinterface

// File: rtl/rx_frame_checker_sat_counter.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter
  import rx_frame_checker_pkg::*;
(
  input  logic             iclk,
  input  logic             irst,
  input  logic             inc_i,
  output logic [CTR_W-1:0] cnt_o
);

  logic [CTR_W-1:0] cnt_q;

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CTR_W{1'b1}})) begin
      cnt_q <= cnt_q + CTR_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rx_frame_checker.sv
// Receive frame checker: validates sop/eop framing and frame length, marks
// bad frames on their last beat and keeps saturating event counters.
module rx_frame_checker
  import rx_frame_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MIN_LEN    = DEF_MIN_LEN,
  parameter int MAX_LEN    = DEF_MAX_LEN
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  ivalid,
  input  logic                  isop,
  input  logic                  ieop,
  input  logic [1:0]            iresidual,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  ibad,
  output logic                  ovalid,
  output logic                  osop,
  output logic                  oeop,
  output logic [1:0]            oresidual,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  obad,
  output logic [CTR_W-1:0]      ogood_cnt,
  output logic [CTR_W-1:0]      orunt_cnt,
  output logic [CTR_W-1:0]      ogiant_cnt,
  output logic [CTR_W-1:0]      oproto_cnt,
  output rx_state_e             ostate
);

  localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_LEN);

  rx_frame_checker_if #(.DATA_WIDTH(DATA_WIDTH)) in_bus ();
  rx_frame_checker_if #(.DATA_WIDTH(DATA_WIDTH)) out_bus ();

  assign in_bus.valid    = ivalid;
  assign in_bus.sop      = isop;
  assign in_bus.eop      = ieop;
  assign in_bus.residual = iresidual;
  assign in_bus.data     = idata;
  assign in_bus.bad      = ibad;

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  hr_ctl_t               hr_q, hr_d;
  logic [DATA_WIDTH-1:0] hr_data_q, hr_data_d;

  logic                  ovalid_q, ovalid_d;
  logic                  osop_q, osop_d;
  logic                  oeop_q, oeop_d;
  logic [1:0]            oresidual_q, oresidual_d;
  logic [DATA_WIDTH-1:0] odata_q, odata_d;
  logic                  obad_q, obad_d;

  logic                  cap, cap_sop, trunc, rel;
  logic [CNT_W-1:0]      bytes, total;
  logic                  is_runt, is_giant;
  logic                  inc_good, inc_runt, inc_giant, inc_proto;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hr_d        = hr_q;
    hr_data_d   = hr_data_q;
    ovalid_d    = 1'b0;
    osop_d      = 1'b0;
    oeop_d      = 1'b0;
    obad_d      = 1'b0;
    oresidual_d = oresidual_q;
    odata_d     = odata_q;
    cap         = 1'b0;
    cap_sop     = 1'b0;
    trunc       = 1'b0;
    rel         = 1'b0;
    inc_good    = 1'b0;
    inc_runt    = 1'b0;
    inc_giant   = 1'b0;
    inc_proto   = 1'b0;
    bytes       = beat_bytes(in_bus.eop, in_bus.residual);
    total       = '0;
    is_runt     = 1'b0;
    is_giant    = 1'b0;

    // Decide whether the incoming beat is kept and whether it opens a frame.
    if (in_bus.valid) begin
      unique case (state_q)
        ST_PKT: begin
          cap       = 1'b1;
          cap_sop   = in_bus.sop;
          trunc     = in_bus.sop;
          inc_proto = in_bus.sop;
        end
        ST_DISCARD: begin
          if (in_bus.sop) begin
            cap       = 1'b1;
            cap_sop   = 1'b1;
            inc_proto = 1'b1;
          end else if (in_bus.eop) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          if (in_bus.sop) begin
            cap     = 1'b1;
            cap_sop = 1'b1;
          end else begin
            inc_proto = 1'b1;
          end
        end
      endcase
    end

    // An eop beat leaves the holding register unconditionally; a mid-frame
    // beat only leaves when its successor arrives, so it can still be
    // closed off as a truncated frame if that successor is a new sop.
    rel = hr_q.vld & (hr_q.eop | cap);
    if (rel) begin
      ovalid_d    = 1'b1;
      osop_d      = hr_q.sop;
      oeop_d      = hr_q.eop | trunc;
      oresidual_d = trunc ? 2'd0 : hr_q.res;
      obad_d      = hr_q.bad | trunc;
      odata_d     = hr_data_q;
      inc_good    = hr_q.eop & ~hr_q.bad;
      hr_d.vld    = 1'b0;
    end

    if (cap) begin
      total     = cap_sop ? bytes : cnt_q + bytes;
      is_runt   = total < MIN_L;
      is_giant  = total > MAX_L;
      cnt_d     = total;
      hr_data_d = in_bus.data;
      hr_d      = '{vld: 1'b1, sop: cap_sop, eop: 1'b1, res: 2'd0, bad: 1'b1};
      if (in_bus.eop) begin
        hr_d.res  = in_bus.residual;
        hr_d.bad  = in_bus.bad | is_runt | is_giant;
        inc_runt  = is_runt;
        inc_giant = is_giant;
        state_d   = ST_IDLE;
      end else if (is_giant) begin
        inc_giant = 1'b1;
        state_d   = ST_DISCARD;
      end else begin
        hr_d.eop = 1'b0;
        hr_d.bad = 1'b0;
        state_d  = ST_PKT;
      end
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hr_q        <= '0;
      hr_data_q   <= '0;
      ovalid_q    <= 1'b0;
      osop_q      <= 1'b0;
      oeop_q      <= 1'b0;
      oresidual_q <= 2'd0;
      odata_q     <= '0;
      obad_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hr_q        <= hr_d;
      hr_data_q   <= hr_data_d;
      ovalid_q    <= ovalid_d;
      osop_q      <= osop_d;
      oeop_q      <= oeop_d;
      oresidual_q <= oresidual_d;
      odata_q     <= odata_d;
      obad_q      <= obad_d;
    end
  end

  assign out_bus.valid    = ovalid_q;
  assign out_bus.sop      = osop_q;
  assign out_bus.eop      = oeop_q;
  assign out_bus.residual = oresidual_q;
  assign out_bus.data     = odata_q;
  assign out_bus.bad      = obad_q;

  assign ovalid    = out_bus.valid;
  assign osop      = out_bus.sop;
  assign oeop      = out_bus.eop;
  assign oresidual = out_bus.residual;
  assign odata     = out_bus.data;
  assign obad      = out_bus.bad;
  assign ostate    = state_q;

  sat_counter u_good_cnt  (.iclk(iclk), .irst(irst), .inc_i(inc_good),  .cnt_o(ogood_cnt));
  sat_counter u_runt_cnt  (.iclk(iclk), .irst(irst), .inc_i(inc_runt),  .cnt_o(orunt_cnt));
  sat_counter u_giant_cnt (.iclk(iclk), .irst(irst), .inc_i(inc_giant), .cnt_o(ogiant_cnt));
  sat_counter u_proto_cnt (.iclk(iclk), .irst(irst), .inc_i(inc_proto), .cnt_o(oproto_cnt));

endmodule

// File: tb/tb_rx_frame_checker.sv
// Directed bench for rx_frame_checker: hand-written frames with expected
// output beats queued in a scoreboard and counters checked after each case.
module tb_rx_frame_checker;
  import rx_frame_checker_pkg::*;

  localparam int W  = 32;
  localparam int EW = W + 5;

  logic iclk = 1'b0;
  logic irst;

  rx_frame_checker_if #(.DATA_WIDTH(W)) in_if ();
  rx_frame_checker_if #(.DATA_WIDTH(W)) out_if ();

  logic [15:0] good_cnt, runt_cnt, giant_cnt, proto_cnt;
  rx_state_e   state_dbg;

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;
  logic [W-1:0]  d;

  always #5 iclk = ~iclk;

  rx_frame_checker #(.DATA_WIDTH(W), .MIN_LEN(64), .MAX_LEN(9216)) dut (
    .iclk       (iclk),
    .irst       (irst),
    .ivalid     (in_if.valid),
    .isop       (in_if.sop),
    .ieop       (in_if.eop),
    .iresidual  (in_if.residual),
    .idata      (in_if.data),
    .ibad       (in_if.bad),
    .ovalid     (out_if.valid),
    .osop       (out_if.sop),
    .oeop       (out_if.eop),
    .oresidual  (out_if.residual),
    .odata      (out_if.data),
    .obad       (out_if.bad),
    .ogood_cnt  (good_cnt),
    .orunt_cnt  (runt_cnt),
    .ogiant_cnt (giant_cnt),
    .oproto_cnt (proto_cnt),
    .ostate     (state_dbg)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every released beat must match the head of exp_q.
  always @(negedge iclk) begin
    if (out_if.valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 64'(out_if.valid), 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("beat", 64'({out_if.sop, out_if.eop, out_if.residual, out_if.bad, out_if.data}),
            64'(mon_exp));
      end
    end else begin
      chk("idle_flags", 64'({out_if.sop, out_if.eop, out_if.bad}), 64'd0);
    end
  end

  task automatic go_idle();
    in_if.valid    = 1'b0;
    in_if.sop      = 1'b0;
    in_if.eop      = 1'b0;
    in_if.residual = 2'd0;
    in_if.bad      = 1'b0;
  endtask

  task automatic drive(input logic sop, input logic eop, input logic [1:0] res,
                       input logic [W-1:0] data, input logic bad);
    in_if.valid    = 1'b1;
    in_if.sop      = sop;
    in_if.eop      = eop;
    in_if.residual = res;
    in_if.data     = data;
    in_if.bad      = bad;
    @(posedge iclk);
    #1;
  endtask

  task automatic expect_beat(input logic sop, input logic eop, input logic [1:0] res,
                             input logic bad, input logic [W-1:0] data);
    exp_q.push_back({sop, eop, res, bad, data});
  endtask

  task automatic send_frame(input int n, input logic [1:0] res, input logic ibad_v,
                            input logic exp_bad, input logic [7:0] id);
    logic [W-1:0] dd;
    for (int i = 1; i <= n; i++) begin
      dd = {id, 24'(i)};
      expect_beat(i == 1, i == n, (i == n) ? res : 2'd0, (i == n) ? exp_bad : 1'b0, dd);
      drive(i == 1, i == n, (i == n) ? res : 2'd0, dd, (i == n) ? ibad_v : 1'b0);
    end
    go_idle();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge iclk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    @(negedge iclk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ovalid"}, 64'(out_if.valid), 64'd0);
    chk({tag, "_osop"}, 64'(out_if.sop), 64'd0);
    chk({tag, "_oeop"}, 64'(out_if.eop), 64'd0);
    chk({tag, "_obad"}, 64'(out_if.bad), 64'd0);
    chk({tag, "_ores"}, 64'(out_if.residual), 64'd0);
    chk({tag, "_odata"}, 64'(out_if.data), 64'd0);
    chk({tag, "_good"}, 64'(good_cnt), 64'd0);
    chk({tag, "_runt"}, 64'(runt_cnt), 64'd0);
    chk({tag, "_giant"}, 64'(giant_cnt), 64'd0);
    chk({tag, "_proto"}, 64'(proto_cnt), 64'd0);
    chk({tag, "_state"}, 64'(state_dbg), 64'(ST_IDLE));
  endtask

  initial begin
    irst = 1'b1;
    go_idle();
    in_if.data = '0;
    repeat (3) @(posedge iclk);
    #1;
    check_zero("reset");
    @(negedge iclk);
    irst = 1'b0;
    @(posedge iclk);
    #1;

    // 100-byte frame, all good
    send_frame(25, 2'd0, 1'b0, 1'b0, 8'h01);
    drain();
    chk("good_100B", 64'(good_cnt), 64'd1);

    // 59-byte runt
    send_frame(15, 2'd3, 1'b0, 1'b1, 8'h02);
    drain();
    chk("runt_59B", 64'(runt_cnt), 64'd1);
    chk("good_after_runt", 64'(good_cnt), 64'd1);

    // sop at beat 10 truncates the open frame at beat 9
    for (int i = 1; i <= 9; i++) begin
      d = {8'h03, 24'(i)};
      expect_beat(i == 1, i == 9, 2'd0, i == 9, d);
      drive(i == 1, 1'b0, 2'd0, d, 1'b0);
    end
    send_frame(16, 2'd0, 1'b0, 1'b0, 8'h04);
    drain();
    chk("proto_trunc", 64'(proto_cnt), 64'd1);
    chk("good_after_trunc", 64'(good_cnt), 64'd2);

    // three orphan beats while idle
    for (int i = 1; i <= 3; i++) drive(1'b0, 1'b0, 2'd0, {8'h05, 24'(i)}, 1'b0);
    go_idle();
    drain();
    chk("proto_orphans", 64'(proto_cnt), 64'd4);

    // giant: eop forced on beat 2305, rest dropped until real eop at 2310
    for (int i = 1; i <= 2310; i++) begin
      d = {8'h06, 24'(i)};
      if (i <= 2304) expect_beat(i == 1, 1'b0, 2'd0, 1'b0, d);
      else if (i == 2305) expect_beat(1'b0, 1'b1, 2'd0, 1'b1, d);
      drive(i == 1, i == 2310, 2'd0, d, 1'b0);
    end
    send_frame(16, 2'd0, 1'b0, 1'b0, 8'h07);
    drain();
    chk("giant_discard", 64'(giant_cnt), 64'd1);
    chk("good_after_giant", 64'(good_cnt), 64'd3);

    // giant whose discard phase is ended by a new sop
    for (int i = 1; i <= 2306; i++) begin
      d = {8'h08, 24'(i)};
      if (i <= 2304) expect_beat(i == 1, 1'b0, 2'd0, 1'b0, d);
      else if (i == 2305) expect_beat(1'b0, 1'b1, 2'd0, 1'b1, d);
      drive(i == 1, 1'b0, 2'd0, d, 1'b0);
    end
    send_frame(16, 2'd0, 1'b0, 1'b0, 8'h09);
    drain();
    chk("giant_sop_in_discard", 64'(giant_cnt), 64'd2);
    chk("proto_sop_in_discard", 64'(proto_cnt), 64'd5);
    chk("good_after_discard_sop", 64'(good_cnt), 64'd4);

    // 9217 bytes ending on a real eop: bad, counted giant
    send_frame(2305, 2'd1, 1'b0, 1'b1, 8'h0A);
    drain();
    chk("giant_real_eop", 64'(giant_cnt), 64'd3);

    // exactly MAX_LEN bytes passes
    send_frame(2304, 2'd0, 1'b0, 1'b0, 8'h0B);
    drain();
    chk("good_max_len", 64'(good_cnt), 64'd5);
    chk("giant_max_len", 64'(giant_cnt), 64'd3);

    // 63 bytes is one short of MIN_LEN
    send_frame(16, 2'd3, 1'b0, 1'b1, 8'h0C);
    drain();
    chk("runt_63B", 64'(runt_cnt), 64'd2);

    // upstream FCS error on a legal-length frame
    send_frame(16, 2'd0, 1'b1, 1'b1, 8'h0D);
    drain();
    chk("good_ibad", 64'(good_cnt), 64'd5);
    chk("runt_ibad", 64'(runt_cnt), 64'd2);

    // counter saturation with back-to-back single-beat runts
    for (int i = 0; i < 65532; i++) send_frame(1, 2'd0, 1'b0, 1'b1, 8'hA0);
    drain();
    chk("runt_fffe", 64'(runt_cnt), 64'hFFFE);
    send_frame(1, 2'd0, 1'b0, 1'b1, 8'hA1);
    drain();
    chk("runt_ffff", 64'(runt_cnt), 64'hFFFF);
    send_frame(1, 2'd0, 1'b0, 1'b1, 8'hA2);
    send_frame(1, 2'd0, 1'b0, 1'b1, 8'hA3);
    drain();
    chk("runt_sat", 64'(runt_cnt), 64'hFFFF);

    // reset in the middle of a frame: beat 5 is still held and must vanish
    for (int i = 1; i <= 5; i++) begin
      d = {8'h0E, 24'(i)};
      if (i <= 4) expect_beat(i == 1, 1'b0, 2'd0, 1'b0, d);
      drive(i == 1, 1'b0, 2'd0, d, 1'b0);
    end
    go_idle();
    @(negedge iclk);
    #2 irst = 1'b1;
    #1 check_zero("rst_mid");
    @(posedge iclk);
    #1 check_zero("rst_mid_edge");
    chk("rst_queue", 64'(exp_q.size()), 64'd0);
    @(negedge iclk);
    irst = 1'b0;
    @(posedge iclk);
    #1;

    drive(1'b0, 1'b1, 2'd0, {8'h0F, 24'd1}, 1'b0);
    go_idle();
    send_frame(16, 2'd0, 1'b0, 1'b0, 8'h10);
    drain();
    chk("proto_post_rst", 64'(proto_cnt), 64'd1);
    chk("good_post_rst", 64'(good_cnt), 64'd1);
    chk("runt_post_rst", 64'(runt_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
